// File: rtl/time_set_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_set_if : button inputs and set-mode controls of the time setter |
// | Revision    : 1.0                                                    |
// +----------------------------------------------------------------------+
interface time_set_if;
    logic       btn_mode;
    logic       btn_adj;
    logic       inc_hrs;
    logic       inc_min;
    logic       clear_sec;
    logic [3:0] blink_mask;
    logic [1:0] mode;

    modport master (
        output btn_mode,
        output btn_adj,
        input  inc_hrs,
        input  inc_min,
        input  clear_sec,
        input  blink_mask,
        input  mode
    );

    modport slave (
        input  btn_mode,
        input  btn_adj,
        output inc_hrs,
        output inc_min,
        output clear_sec,
        output blink_mask,
        output mode
    );
endinterface
`default_nettype wire

// File: rtl/time_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | time_set_controller : two-button clock setting FSM with auto-repeat, |
// |                       idle timeout and digit blinking                |
// | Revision            : 1.0                                            |
// +----------------------------------------------------------------------+
module time_set_controller #(
    parameter int TICK_DIV        = 32,
    parameter int REPEAT_DELAY_MS = 500,
    parameter int REPEAT_RATE_MS  = 125,
    parameter int TIMEOUT_MS      = 10000,
    parameter int BLINK_HALF_MS   = 250
) (
    input  wire logic clk,
    input  wire logic reset,
    time_set_if.slave bus
);

    localparam logic [1:0] c_ST_RUN     = 2'b00;
    localparam logic [1:0] c_ST_SET_HRS = 2'b01;
    localparam logic [1:0] c_ST_SET_MIN = 2'b10;

    localparam int c_PRESC_W  = $clog2(TICK_DIV) + 1;
    localparam int c_HOLD_MAX = (REPEAT_DELAY_MS > REPEAT_RATE_MS) ? REPEAT_DELAY_MS : REPEAT_RATE_MS;
    localparam int c_HOLD_W   = $clog2(c_HOLD_MAX) + 1;
    localparam int c_IDLE_W   = $clog2(TIMEOUT_MS) + 1;
    localparam int c_BLINK_W  = $clog2(BLINK_HALF_MS) + 1;

    localparam logic [c_PRESC_W-1:0] c_PRESC_LAST  = c_PRESC_W'(TICK_DIV - 1);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_DELAY  = c_HOLD_W'(REPEAT_DELAY_MS);
    localparam logic [c_HOLD_W-1:0]  c_HOLD_RATE   = c_HOLD_W'(REPEAT_RATE_MS);
    localparam logic [c_IDLE_W-1:0]  c_IDLE_LIMIT  = c_IDLE_W'(TIMEOUT_MS);
    localparam logic [c_BLINK_W-1:0] c_BLINK_LIMIT = c_BLINK_W'(BLINK_HALF_MS);

    logic [c_PRESC_W-1:0] r_presc;
    logic                 r_armed;
    logic                 r_mode_q;
    logic                 r_adj_q;
    logic [1:0]           r_state;
    logic                 r_hold_active;
    logic                 r_repeating;
    logic [c_HOLD_W-1:0]  r_hold_cnt;
    logic [c_IDLE_W-1:0]  r_idle_cnt;
    logic [c_BLINK_W-1:0] r_blink_cnt;
    logic                 r_phase;
    logic                 r_inc_hrs;
    logic                 r_inc_min;
    logic                 r_clear_pend;
    logic                 r_clear_sec;

    logic                 w_tick;
    logic                 w_in_set;
    logic                 w_mode_rise;
    logic                 w_adj_rise;
    logic                 w_adj_held;
    logic                 w_activity;
    logic [c_HOLD_W-1:0]  w_hold_next;
    logic [c_HOLD_W-1:0]  w_hold_limit;
    logic                 w_hold_fire;
    logic [c_IDLE_W-1:0]  w_idle_next;
    logic                 w_timeout;
    logic [c_BLINK_W-1:0] w_blink_next;
    logic                 w_inc_fire;

    assign w_tick   = (r_presc == c_PRESC_LAST);
    assign w_in_set = (r_state == c_ST_SET_HRS) || (r_state == c_ST_SET_MIN);

    // r_armed masks the first sample after reset so a button already held is not an edge
    assign w_mode_rise = r_armed & bus.btn_mode & ~r_mode_q;
    assign w_adj_rise  = r_armed & bus.btn_adj  & ~r_adj_q;
    assign w_adj_held  = r_armed & bus.btn_adj  &  r_adj_q;
    assign w_activity  = (r_armed & ((bus.btn_mode ^ r_mode_q) | (bus.btn_adj ^ r_adj_q))) | w_adj_held;

    assign w_hold_next  = (r_hold_cnt == '1) ? r_hold_cnt : r_hold_cnt + c_HOLD_W'(1);
    assign w_hold_limit = r_repeating ? c_HOLD_RATE : c_HOLD_DELAY;
    assign w_hold_fire  = w_adj_held & r_hold_active & w_tick & (w_hold_next >= w_hold_limit);

    assign w_idle_next  = (r_idle_cnt == '1) ? r_idle_cnt : r_idle_cnt + c_IDLE_W'(1);
    assign w_timeout    = w_in_set & w_tick & ~w_activity & (w_idle_next >= c_IDLE_LIMIT);

    assign w_blink_next = (r_blink_cnt == '1) ? r_blink_cnt : r_blink_cnt + c_BLINK_W'(1);

    // A mode edge wins over a coincident adjust edge
    assign w_inc_fire = w_in_set & ~w_mode_rise & (w_adj_rise | w_hold_fire);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_presc       <= '0;
            r_armed       <= 1'b0;
            r_mode_q      <= 1'b0;
            r_adj_q       <= 1'b0;
            r_state       <= c_ST_RUN;
            r_hold_active <= 1'b0;
            r_repeating   <= 1'b0;
            r_hold_cnt    <= '0;
            r_idle_cnt    <= '0;
            r_blink_cnt   <= '0;
            r_phase       <= 1'b0;
            r_inc_hrs     <= 1'b0;
            r_inc_min     <= 1'b0;
            r_clear_pend  <= 1'b0;
            r_clear_sec   <= 1'b0;
        end else begin
            r_presc      <= w_tick ? '0 : r_presc + c_PRESC_W'(1);
            r_armed      <= 1'b1;
            r_mode_q     <= bus.btn_mode;
            r_adj_q      <= bus.btn_adj;
            r_inc_hrs    <= 1'b0;
            r_inc_min    <= 1'b0;
            r_clear_pend <= 1'b0;
            r_clear_sec  <= r_clear_pend;

            case (r_state)
                c_ST_SET_HRS, c_ST_SET_MIN: begin
                    if (w_mode_rise || w_timeout) begin
                        if (w_mode_rise && (r_state == c_ST_SET_HRS)) begin
                            r_state <= c_ST_SET_MIN;
                        end else begin
                            r_state      <= c_ST_RUN;
                            r_clear_pend <= 1'b1;
                        end
                        r_hold_active <= 1'b0;
                        r_repeating   <= 1'b0;
                        r_hold_cnt    <= '0;
                        r_idle_cnt    <= '0;
                        r_blink_cnt   <= '0;
                        r_phase       <= 1'b0;
                    end else begin
                        if (w_adj_rise) begin
                            r_hold_active <= 1'b1;
                            r_repeating   <= 1'b0;
                            r_hold_cnt    <= '0;
                        end else if (!(w_adj_held && r_hold_active)) begin
                            r_hold_active <= 1'b0;
                            r_repeating   <= 1'b0;
                            r_hold_cnt    <= '0;
                        end else if (w_tick) begin
                            if (w_hold_fire) begin
                                r_hold_cnt  <= '0;
                                r_repeating <= 1'b1;
                            end else begin
                                r_hold_cnt <= w_hold_next;
                            end
                        end

                        // Every increment restarts the blink so the new value is shown at once
                        if (w_inc_fire) begin
                            r_inc_hrs   <= (r_state == c_ST_SET_HRS);
                            r_inc_min   <= (r_state == c_ST_SET_MIN);
                            r_phase     <= 1'b0;
                            r_blink_cnt <= '0;
                        end else if (w_tick) begin
                            if (w_blink_next >= c_BLINK_LIMIT) begin
                                r_phase     <= ~r_phase;
                                r_blink_cnt <= '0;
                            end else begin
                                r_blink_cnt <= w_blink_next;
                            end
                        end

                        if (w_activity) begin
                            r_idle_cnt <= '0;
                        end else if (w_tick) begin
                            r_idle_cnt <= w_idle_next;
                        end
                    end
                end

                default: begin
                    r_state       <= w_mode_rise ? c_ST_SET_HRS : c_ST_RUN;
                    r_hold_active <= 1'b0;
                    r_repeating   <= 1'b0;
                    r_hold_cnt    <= '0;
                    r_idle_cnt    <= '0;
                    r_blink_cnt   <= '0;
                    r_phase       <= 1'b0;
                end
            endcase
        end
    end

    assign bus.inc_hrs    = r_inc_hrs;
    assign bus.inc_min    = r_inc_min;
    assign bus.clear_sec  = r_clear_sec;
    assign bus.mode       = r_state;
    assign bus.blink_mask = (r_state == c_ST_SET_HRS) ? {r_phase, r_phase, 2'b00} :
                            (r_state == c_ST_SET_MIN) ? {2'b00, r_phase, r_phase} : 4'b0000;

endmodule
`default_nettype wire

// File: tb/tb_time_set_controller.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_time_set_controller : event scoreboard bench for the time setter  |
// | Revision               : 1.0                                         |
// +----------------------------------------------------------------------+
module tb_time_set_controller;

    typedef struct {
        byte        kind;
        int         cyc;
        logic [3:0] val;
    } ev_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   cyc;
    int   n_checks = 0;
    int   n_fail   = 0;
    logic chk_blink = 1'b0;
    ev_t  exp_q[$];

    always #5 clk = ~clk;

    time_set_if bus ();

    time_set_controller #(
        .TICK_DIV        (4),
        .REPEAT_DELAY_MS (5),
        .REPEAT_RATE_MS  (2),
        .TIMEOUT_MS      (20),
        .BLINK_HALF_MS   (3)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    // Cycle n is the interval following the n-th rising edge after reset release
    always @(posedge clk) begin
        if (reset) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    task automatic check(input string name, input int act, input int req);
        n_checks++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    task automatic check_zero(input string name);
        check(name, int'({bus.mode, bus.inc_hrs, bus.inc_min, bus.clear_sec, bus.blink_mask}), 0);
    endtask

    task automatic push(input byte k, input int c, input logic [3:0] v);
        ev_t e;
        e.kind = k;
        e.cyc  = c;
        e.val  = v;
        exp_q.push_back(e);
    endtask

    task automatic observe(input byte k, input logic [3:0] v);
        ev_t e;
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_event: got %c/%0h at cycle %0d, required no event", k, v, cyc);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != k || e.cyc != cyc || e.val != v) begin
                n_fail++;
                $display("FAIL event_%c: got %c/%0h at cycle %0d, required %c/%0h at cycle %0d",
                         e.kind, k, v, cyc, e.kind, e.val, e.cyc);
            end
        end
    endtask

    // Monitor: O = mode change, B = blink mask change, H/M = inc pulses, C = clear_sec
    initial begin
        logic [1:0] prev_mode;
        logic [3:0] prev_mask;
        prev_mode = 2'b00;
        prev_mask = 4'b0000;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                prev_mode = 2'b00;
                prev_mask = 4'b0000;
            end else begin
                if (bus.inc_hrs || bus.inc_min)
                    check("inc_exclusive", int'({bus.inc_hrs, bus.inc_min}) == 3 ? 1 : 0, 0);
                if (bus.mode != prev_mode)
                    observe("O", {2'b00, bus.mode});
                if (chk_blink && bus.blink_mask != prev_mask)
                    observe("B", bus.blink_mask);
                if (bus.inc_hrs)   observe("H", 4'h0);
                if (bus.inc_min)   observe("M", 4'h0);
                if (bus.clear_sec) observe("C", 4'h0);
                prev_mode = bus.mode;
                prev_mask = bus.blink_mask;
            end
        end
    end

    task automatic goto(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic press_mode(input int c);
        goto(c);
        bus.btn_mode = 1'b1;
        goto(c + 1);
        bus.btn_mode = 1'b0;
    endtask

    task automatic do_reset(input string tag, input logic hold_mode);
        @(negedge clk);
        reset = 1'b1;
        #1;
        check_zero({tag, "_assert"});
        bus.btn_mode = hold_mode;
        repeat (3) @(negedge clk);
        check_zero({tag, "_hold"});
        reset = 1'b0;
    endtask

    task automatic end_scenario(input string tag);
        check({tag, "_pending"}, exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        bus.btn_mode = 1'b0;
        bus.btn_adj  = 1'b0;

        // Reset holds outputs at zero even with both buttons pressed
        repeat (2) @(negedge clk);
        bus.btn_mode = 1'b1;
        bus.btn_adj  = 1'b1;
        @(negedge clk);
        check_zero("reset_with_buttons");
        bus.btn_adj = 1'b0;
        do_reset("rst_a", 1'b0);

        // Mode cycling: RUN->SET_HRS->SET_MIN->RUN, clear_sec one cycle after return
        push("O", 3, 4'h1);
        push("O", 7, 4'h2);
        push("O", 11, 4'h0);
        push("C", 12, 4'h0);
        press_mode(2);
        press_mode(6);
        press_mode(10);
        goto(20);
        end_scenario("modes");

        // Auto-repeat in SET_HRS: adj held for cycles 8..47
        do_reset("rst_b", 1'b0);
        push("O", 3, 4'h1);
        push("H", 9, 4'h0);
        push("H", 28, 4'h0);
        push("H", 36, 4'h0);
        push("H", 44, 4'h0);
        press_mode(2);
        goto(8);
        bus.btn_adj = 1'b1;
        goto(48);
        bus.btn_adj = 1'b0;
        goto(56);
        end_scenario("repeat");

        // Adjust in RUN is ignored and the mask stays blank-free
        do_reset("rst_c", 1'b0);
        chk_blink = 1'b1;
        for (int i = 0; i < 3; i++) begin
            goto(3 + 4 * i);
            bus.btn_adj = 1'b1;
            goto(4 + 4 * i);
            bus.btn_adj = 1'b0;
        end
        goto(20);
        check("run_mode", int'(bus.mode), 0);
        check("run_mask", int'(bus.blink_mask), 0);
        end_scenario("run_adj");
        chk_blink = 1'b0;

        // Idle timeout in SET_MIN with minute digits blinking every 12 cycles
        do_reset("rst_d", 1'b0);
        chk_blink = 1'b1;
        push("O", 3, 4'h1);
        push("O", 7, 4'h2);
        push("B", 16, 4'h3);
        push("B", 28, 4'h0);
        push("B", 40, 4'h3);
        push("B", 52, 4'h0);
        push("B", 64, 4'h3);
        push("B", 76, 4'h0);
        push("O", 88, 4'h0);
        push("C", 89, 4'h0);
        press_mode(2);
        press_mode(6);
        goto(100);
        chk_blink = 1'b0;
        end_scenario("timeout");

        // Coincident mode and adjust edges in SET_HRS: mode wins, no increment
        do_reset("rst_e", 1'b0);
        push("O", 3, 4'h1);
        push("O", 7, 4'h2);
        press_mode(2);
        goto(6);
        bus.btn_mode = 1'b1;
        bus.btn_adj  = 1'b1;
        goto(7);
        bus.btn_mode = 1'b0;
        bus.btn_adj  = 1'b0;
        goto(20);
        end_scenario("coincident");

        // Reset mid auto-repeat, then buttons already high at release give no edge
        do_reset("rst_f", 1'b0);
        push("O", 3, 4'h1);
        push("H", 9, 4'h0);
        push("H", 28, 4'h0);
        press_mode(2);
        goto(8);
        bus.btn_adj = 1'b1;
        goto(30);
        end_scenario("pre_abort");
        do_reset("abort", 1'b1);
        push("O", 7, 4'h1);
        push("H", 17, 4'h0);
        goto(3);
        bus.btn_mode = 1'b0;
        press_mode(6);
        goto(12);
        bus.btn_adj = 1'b0;
        goto(16);
        bus.btn_adj = 1'b1;
        goto(17);
        bus.btn_adj = 1'b0;
        goto(24);
        end_scenario("post_abort");

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required summary before limit");
        $fatal(1, "time limit");
    end

endmodule
`default_nettype wire

// File: doc/time_set_controller.md
TIME_SET_CONTROLLER -- requirements
Module: time_set_controller

Interface
REQ-001 SHALL have parameter TICK_DIV, default 32: clk cycles per 1 ms tick (32768 Hz clock).
REQ-002 SHALL have parameter REPEAT_DELAY_MS, default 500: hold time before auto-repeat starts.
REQ-003 SHALL have parameter REPEAT_RATE_MS, default 125: auto-repeat period.
REQ-004 SHALL have parameter TIMEOUT_MS, default 10000: idle time before a set mode auto-exits.
REQ-005 SHALL have parameter BLINK_HALF_MS, default 250: blink half-period.
REQ-006 SHALL have port clk, input, 1: the single clock.
REQ-007 SHALL have port reset, input, 1: asynchronous, active-high reset.
REQ-008 SHALL have port btn_mode, input, 1: debounced level, 1 = pressed.
REQ-009 SHALL have port btn_adj, input, 1: debounced level, 1 = pressed.
REQ-010 SHALL have port inc_hrs, output, 1: one-cycle pulse, hours +1 to the time datapath.
REQ-011 SHALL have port inc_min, output, 1: one-cycle pulse, minutes +1 to the time datapath.
REQ-012 SHALL have port clear_sec, output, 1: one-cycle pulse, zero seconds and quarter LEDs.
REQ-013 SHALL have port blink_mask, output, 4: per-digit blank enable; bit0 min_u, bit1 min_d, bit2 hrs_u, bit3 hrs_d; 1 = blank.
REQ-014 SHALL have port mode, output, 2: 00 RUN, 01 SET_HRS, 10 SET_MIN.

Function
REQ-015 SHALL generate a 1-cycle ms_tick every TICK_DIV clk cycles from a free-running prescaler.
REQ-016 SHALL register both buttons once and detect rising edges against the registered value.
REQ-017 SHALL sequence states on btn_mode rising edge: RUN->SET_HRS->SET_MIN->RUN.
REQ-018 SHALL pulse clear_sec in the cycle after the SET_MIN->RUN transition.
REQ-019 SHALL ignore btn_adj in RUN: no inc pulses.
REQ-020 SHALL, in SET_HRS/SET_MIN, pulse inc_hrs/inc_min 1 cycle after a btn_adj rising edge.
REQ-021 SHALL, while btn_adj held in a set state, issue a further pulse after REPEAT_DELAY_MS ms_ticks, then every REPEAT_RATE_MS ms_ticks until release.
REQ-022 SHALL stop auto-repeat and clear the hold counter on btn_adj release or on any state change.
REQ-023 SHALL, on simultaneous btn_mode and btn_adj rising edges, honour the mode edge only; no inc pulse that cycle.
REQ-024 SHALL count ms_ticks of idle time in a set state; any button edge or held btn_adj clears the count.
REQ-025 SHALL, at TIMEOUT_MS idle ticks, return to RUN and pulse clear_sec once.
REQ-026 SHALL toggle blink phase every BLINK_HALF_MS ms_ticks; phase forced to 0 (visible) on set-state entry and on every inc pulse.
REQ-027 SHALL drive blink_mask = {p,p,0,0} in SET_HRS, {0,0,p,p} in SET_MIN, 0000 in RUN, where p = phase.
REQ-028 SHALL never assert inc_hrs and inc_min in the same cycle.
REQ-029 SHALL saturate all ms counters; widths sized by $clog2 of their parameter + 1.

Reset
REQ-030 SHALL, while reset = 1, hold mode = 00, all pulses = 0, blink_mask = 0000, and clear all counters and edge registers.
REQ-031 SHALL abort any set mode or auto-repeat on reset mid-operation with no clear_sec pulse.
REQ-032 SHALL treat a button already high at reset release as no edge.

Verification (TICK_DIV=4, REPEAT_DELAY_MS=5, REPEAT_RATE_MS=2, TIMEOUT_MS=20, BLINK_HALF_MS=3)
REQ-033 SHALL cover: 3 btn_mode presses -> mode 01, 10, 00; exactly one clear_sec, 1 cycle after return to 00.
REQ-034 SHALL cover: SET_HRS, btn_adj held 40 cycles -> inc_hrs pulses at press+1, +20, +28, +36 cycles; 4 pulses total.
REQ-035 SHALL cover: RUN, btn_adj pulsed 3 times -> zero inc pulses; blink_mask stays 0000.
REQ-036 SHALL cover: SET_MIN idle 80 cycles -> mode 00 and one clear_sec; blink_mask {0,0,p,p} toggles every 12 cycles before exit.
REQ-037 SHALL cover: btn_mode and btn_adj rise same cycle in SET_HRS -> mode 10, no inc_hrs or inc_min.
REQ-038 SHALL cover: reset asserted mid auto-repeat -> outputs zero same cycle; after release mode 00 with btn_adj still high gives no pulse.
